multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
Iterative 32-bit signed multiply/divide unit. It sits between the register file read ports and the register file write port.
- Consumes operands read from regfile ports A/B.
- After a fixed multi-cycle latency, returns a result, an exception flag and the captured destination register index, so the writeback logic can drive the regfile write port.
- Runs one operation at a time; there is no queue.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
REG_ADDR_W, 5, width of destination register tag.

Ports:
clock  input  1  single clock, all state updates on rising edge
ctrl_reset_n  input  1  reset, asynchronous, active-low
ctrl_MULT  input  1  start signed multiply; sampled each rising edge
ctrl_DIV  input  1  start signed divide; sampled each rising edge
data_operandA  input  32  multiplicand / dividend (regfile port A data)
data_operandB  input  32  multiplier / divisor (regfile port B data)
ctrl_destReg  input  5  destination register tag captured at start
data_result  output  32  product low word or quotient
data_exception  output  1  overflow / divide-by-zero / quotient overflow
data_resultRDY  output  1  one-cycle pulse: result, exception and tag valid
result_destReg  output  5  tag of the completed operation
busy  output  1  operation in flight

Behaviour:
- Reset (ctrl_reset_n low, asynchronous): state IDLE, counter 0.
  - data_result=0, data_exception=0, data_resultRDY=0, result_destReg=0, busy=0.
  - Reset takes effect immediately and aborts any in-flight op with no RDY pulse.
- States: IDLE, MUL, DIV, DONE.
- Start at edge E0:
  - ctrl_MULT=1 → MUL; ctrl_DIV=1 → DIV.
  - Both high → MUL (MULT priority).
  - On the start edge: latch operands and ctrl_destReg, clear counter, busy=1.
- Start while busy (MUL/DIV/DONE): abort the current op and restart with the new operands and tag. The aborted op never pulses RDY.
- Iterations:
  - One per edge, E1..E32; counter 0..31.
  - MUL: radix-2 Booth on 32x32 signed operands, 65-bit product register.
  - DIV: restoring division on operand magnitudes, 32-bit quotient and 33-bit partial remainder, with sign fix-up at the end.
- Completion:
  - At edge E32+1 = E33 the state enters DONE and the outputs register.
  - data_resultRDY=1 for exactly the cycle E33→E34.
  - Next edge: IDLE, busy=0, RDY=0.
  - Total latency 33 edges from the start edge; busy is high from E0 through E34.
- Output hold: data_result, data_exception and result_destReg hold their values until the next completion or reset. A start does not clear them.
- MUL arithmetic:
  - result = product[31:0].
  - exception=1 iff product[63:32] is not the sign-extension of product[31].
- DIV arithmetic:
  - Quotient truncates toward zero; the remainder is discarded.
  - Quotient sign = signA XOR signB; a zero quotient is never negative.
  - Divisor 0: result=0, exception=1, same 33-edge latency.
  - 0x80000000 / 0xFFFFFFFF: result=0x80000000, exception=1.
  - Otherwise exception=0.
- Operand inputs are don't-care outside the start edge.

Decomposition:
- Shared package multdiv_pkg holds:
  - DATA_WIDTH and REG_ADDR_W.
  - State encoding constants IDLE/MUL/DIV/DONE.
  - ITER_LAST=31 and the INT_MIN constant 0x80000000.
- One sub-module, multdiv_addsub: 33-bit two's-complement add/subtract with a sub control.
  - Time-shared by the Booth step (add/sub multiplicand) and the restoring step (trial subtract).
  - Instanced once.

Test Plan:
1. Reset, then ctrl_MULT with A=7, B=6, tag=3 → RDY exactly at E33, result=42, exception=0, result_destReg=3, busy low after E34.
2. MULT A=0xFFFFFFFD (-3), B=5 → result=0xFFFFFFF1, exception=0; then A=0x00010000, B=0x00010000 → result=0x00000000, exception=1.
3. DIV A=0xFFFFFFEF (-17), B=5 → result=0xFFFFFFFD (-3), exception=0; DIV A=17, B=0xFFFFFFFB (-5) → 0xFFFFFFFD.
4. DIV A=100, B=0 → result=0, exception=1 at E33; DIV A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1.
5. MULT 7×6 tag=1; at E10 DIV A=20, B=4, tag=9 → no RDY at the original E33; RDY 33 edges after E10, result=5, result_destReg=9.
6. Mid-operation (counter=15) drive ctrl_reset_n low asynchronously, between edges → outputs zero immediately, busy=0, no RDY pulse. Reassert high, then ctrl_MULT and ctrl_DIV together with A=3, B=4 → result=12 (MULT priority).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and helpers for the iterative signed multiply/divide unit.
package multdiv_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = $clog2(DATA_WIDTH);
   localparam int ITER_LAST  = DATA_WIDTH - 1;

   localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Magnitude of a two's-complement value; INT_MIN maps to its unsigned magnitude.
   function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v);
      return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between regfile read ports, the unit, and writeback.
interface multdiv_if;
   import multdiv_pkg::*;

   logic                  ctrl_MULT;
   logic                  ctrl_DIV;
   logic [DATA_WIDTH-1:0] data_operandA;
   logic [DATA_WIDTH-1:0] data_operandB;
   logic [REG_ADDR_W-1:0] ctrl_destReg;
   logic [DATA_WIDTH-1:0] data_result;
   logic                  data_exception;
   logic                  data_resultRDY;
   logic [REG_ADDR_W-1:0] result_destReg;
   logic                  busy;

   modport master (
      output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
      input  data_result, data_exception, data_resultRDY, result_destReg, busy
   );

   modport slave (
      input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
      output data_result, data_exception, data_resultRDY, result_destReg, busy
   );

endinterface

// File: rtl/multdiv_addsub.sv
// Two's-complement adder/subtractor shared by the Booth and restoring steps.
module multdiv_addsub #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   assign y = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit, one op
// at a time, fixed 33-edge latency from the start edge to the RDY pulse.
module multdiv_unit
   import multdiv_pkg::*;
(
   input  logic      clock,
   input  logic      ctrl_reset_n,
   multdiv_if.slave  bus
);

   localparam int DW = DATA_WIDTH;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               iter_done;
   logic [REG_ADDR_W-1:0] tag_q;

   // Booth: {accumulator, multiplier, q(-1)}; product ends up in prod[2*DW:1].
   logic [2*DW:0]      prod;
   logic [DW-1:0]      mcand;

   // Restoring divide: quotient shifts in from the dividend magnitude.
   logic [DW-1:0]      rem;
   logic [DW-1:0]      quo;
   logic [DW-1:0]      dvsr;
   logic               neg_q, div_zero, div_ovf;

   logic [DW-1:0]      res_q;
   logic               exc_q;
   logic [REG_ADDR_W-1:0] rtag_q;

   logic               start, running, finish;
   logic [DW:0]        as_a, as_b, as_y;
   logic               as_sub;
   logic [DW-1:0]      div_res;

   assign start   = bus.ctrl_MULT | bus.ctrl_DIV;
   assign running = (state == MUL) || (state == DIV);
   assign finish  = running && iter_done && !start;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = IDLE;
         MUL,
         DIV:     if (iter_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // A new start aborts whatever is in flight; MULT wins over DIV.
      if (bus.ctrl_MULT)     state_nxt = MUL;
      else if (bus.ctrl_DIV) state_nxt = DIV;
   end

   // ------------------------------------------------------ shared adder
   always_comb begin
      as_a   = '0;
      as_b   = '0;
      as_sub = 1'b0;
      if (state == DIV) begin
         as_a   = {rem, quo[DW-1]};
         as_b   = {1'b0, dvsr};
         as_sub = 1'b1;
      end else begin
         as_a   = {prod[2*DW], prod[2*DW:DW+1]};
         as_sub = (prod[1:0] == 2'b10);
         if (prod[1] != prod[0]) as_b = {mcand[DW-1], mcand};
      end
   end

   multdiv_addsub #(.W(DW+1)) u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .y   (as_y)
   );

   assign div_res = neg_q ? (~quo + 1'b1) : quo;

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         cnt       <= '0;
         iter_done <= 1'b0;
         tag_q     <= '0;
         prod      <= '0;
         mcand     <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         neg_q     <= 1'b0;
         div_zero  <= 1'b0;
         div_ovf   <= 1'b0;
         res_q     <= '0;
         exc_q     <= 1'b0;
         rtag_q    <= '0;
      end else begin
         if (start) begin
            cnt       <= '0;
            iter_done <= 1'b0;
            tag_q     <= bus.ctrl_destReg;
            prod      <= {{DW{1'b0}}, bus.data_operandB, 1'b0};
            mcand     <= bus.data_operandA;
            rem       <= '0;
            quo       <= mag(bus.data_operandA);
            dvsr      <= mag(bus.data_operandB);
            neg_q     <= bus.data_operandA[DW-1] ^ bus.data_operandB[DW-1];
            div_zero  <= (bus.data_operandB == '0);
            div_ovf   <= (bus.data_operandA == INT_MIN) && (&bus.data_operandB);
         end else if (running && !iter_done) begin
            if (cnt == CNT_W'(ITER_LAST)) iter_done <= 1'b1;
            else                          cnt       <= cnt + 1'b1;
            if (state == MUL) begin
               // Adder result is exact in 33 bits, so the shift keeps its sign bit.
               prod <= {as_y, prod[DW:1]};
            end else if (as_y[DW]) begin
               rem <= as_a[DW-1:0];
               quo <= {quo[DW-2:0], 1'b0};
            end else begin
               rem <= as_y[DW-1:0];
               quo <= {quo[DW-2:0], 1'b1};
            end
         end

         if (finish) begin
            rtag_q <= tag_q;
            if (state == MUL) begin
               res_q <= prod[DW:1];
               exc_q <= (prod[2*DW:DW+1] != {DW{prod[DW]}});
            end else if (div_zero) begin
               res_q <= '0;
               exc_q <= 1'b1;
            end else if (div_ovf) begin
               res_q <= INT_MIN;
               exc_q <= 1'b1;
            end else begin
               res_q <= div_res;
               exc_q <= 1'b0;
            end
         end
      end
   end

   assign bus.data_result    = res_q;
   assign bus.data_exception = exc_q;
   assign bus.result_destReg = rtag_q;
   assign bus.data_resultRDY = (state == DONE);
   assign bus.busy           = (state != IDLE);

endmodule
